// File: rtl/mipi_rx_raw_depacker_gen.sv
// CSI-2 RAW8/10/12/14 depacker: byte gearbox turning LANES payload bytes per
// cycle into LANES MSB-aligned pixels per beat, with per-line count/residual report.
module mipi_rx_raw_depacker_gen #(
  parameter int LANES       = 4,
  parameter int PIXEL_WIDTH = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           data_valid_i,
  input  logic [8*LANES-1:0]             data_i,
  input  logic [2:0]                     packet_type_i,
  output logic                           output_valid_o,
  output logic [PIXEL_WIDTH*LANES-1:0]   output_o,
  output logic                           line_done_o,
  output logic [15:0]                    line_pixel_count_o,
  output logic                           residual_error_o
);

  localparam int BUF_BYTES = 3 * LANES;
  localparam int CAT_BYTES = 4 * LANES;
  localparam int BUF_W     = 8 * BUF_BYTES;
  localparam int FW        = $clog2(CAT_BYTES + 1);
  localparam int SW        = FW + 3;

  logic [BUF_W-1:0]           buf_reg;
  logic [BUF_W-1:0]           buf_next;
  logic [FW-1:0]              fill_reg;
  logic [FW-1:0]              fill_next;
  logic [2:0]                 type_reg;
  logic                       in_line_reg;
  logic [15:0]                count_reg;

  logic [2:0]                 cur_type;
  logic                       supported;
  logic [FW-1:0]              need;
  logic [FW-1:0]              total;
  logic                       emit;
  logic                       line_end;
  logic [SW-1:0]              fill_sh;
  logic [SW-1:0]              need_sh;
  logic [8*CAT_BYTES-1:0]     cat;
  logic [16:0]                count_sum;
  logic [PIXEL_WIDTH*LANES-1:0] pix_bus;

  // The type seen on the first valid cycle is used immediately, then held.
  always_comb begin
    cur_type  = in_line_reg ? type_reg : packet_type_i;
    supported = 1'b1;
    need      = FW'(LANES);
    case (cur_type)
      3'd2:    need = FW'(LANES);
      3'd3:    need = FW'(5 * LANES / 4);
      3'd4:    need = FW'(3 * LANES / 2);
      3'd5:    need = FW'(7 * LANES / 4);
      default: supported = 1'b0;
    endcase
  end

  assign total     = fill_reg + FW'(LANES);
  assign emit      = data_valid_i && supported && (total >= need);
  assign line_end  = !data_valid_i && in_line_reg;
  assign fill_sh   = {fill_reg, 3'b000};
  assign need_sh   = {need, 3'b000};
  assign count_sum = {1'b0, count_reg} + 17'(LANES);

  // Bytes above the fill level are always zero, so the new word can be OR-ed in.
  assign cat = {{(8*LANES){1'b0}}, buf_reg}
             | ({{BUF_W{1'b0}}, data_i} << fill_sh);

  always_comb begin
    buf_next  = BUF_W'(cat);
    fill_next = total;
    if (emit) begin
      buf_next  = BUF_W'(cat >> need_sh);
      fill_next = total - need;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_pix
    localparam int B10 = 5 * (gi / 4);
    localparam int I10 = gi % 4;
    localparam int B12 = 3 * (gi / 2);
    localparam int I12 = gi % 2;
    localparam int B14 = 7 * (gi / 4);
    localparam int I14 = gi % 4;
    logic [15:0] p16;

    always_comb begin
      case (cur_type)
        3'd3:    p16 = {cat[8*(B10+I10) +: 8], cat[8*(B10+4)+2*I10 +: 2], 6'b0};
        3'd4:    p16 = {cat[8*(B12+I12) +: 8], cat[8*(B12+2)+4*I12 +: 4], 4'b0};
        3'd5:    p16 = {cat[8*(B14+I14) +: 8], cat[8*(B14+4)+6*I14 +: 6], 2'b0};
        default: p16 = {cat[8*gi +: 8], 8'b0};
      endcase
    end

    // Earliest pixel goes to the most significant slot.
    assign pix_bus[(LANES-1-gi)*PIXEL_WIDTH +: PIXEL_WIDTH] = p16[15 -: PIXEL_WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      output_valid_o     <= 1'b0;
      output_o           <= '0;
      line_done_o        <= 1'b0;
      line_pixel_count_o <= 16'h0;
      residual_error_o   <= 1'b0;
      buf_reg            <= '0;
      fill_reg           <= '0;
      type_reg           <= 3'd0;
      in_line_reg        <= 1'b0;
      count_reg          <= 16'h0;
    end else begin
      output_valid_o     <= emit;
      output_o           <= emit ? pix_bus : '0;
      line_done_o        <= line_end;
      line_pixel_count_o <= line_end ? count_reg : 16'h0;
      residual_error_o   <= line_end && (fill_reg != '0);
      if (data_valid_i) begin
        in_line_reg <= 1'b1;
        if (!in_line_reg) type_reg <= packet_type_i;
        if (supported) begin
          buf_reg  <= buf_next;
          fill_reg <= fill_next;
        end
        if (emit) count_reg <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
      end else begin
        in_line_reg <= 1'b0;
        buf_reg     <= '0;
        fill_reg    <= '0;
        count_reg   <= 16'h0;
      end
    end
  end

endmodule

// File: tb/tb_mipi_rx_raw_depacker_gen.sv
// Randomised line stimulus for LANES=4 and LANES=8 depackers, checked against
// an arithmetic unpacking model of the CSI-2 RAW formats.
module tb_mipi_rx_raw_depacker_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         dv4, dv8;
  logic [31:0]  d4;
  logic [63:0]  d8;
  logic [2:0]   pt4, pt8;
  logic         ov4, ov8;
  logic [63:0]  o4;
  logic [127:0] o8;
  logic         ld4, ld8;
  logic [15:0]  cnt4, cnt8;
  logic         re4, re8;

  mipi_rx_raw_depacker_gen #(.LANES(4), .PIXEL_WIDTH(16)) dut4 (
    .clk_i(clk), .reset_i(rst), .data_valid_i(dv4), .data_i(d4),
    .packet_type_i(pt4), .output_valid_o(ov4), .output_o(o4),
    .line_done_o(ld4), .line_pixel_count_o(cnt4), .residual_error_o(re4)
  );

  mipi_rx_raw_depacker_gen #(.LANES(8), .PIXEL_WIDTH(16)) dut8 (
    .clk_i(clk), .reset_i(rst), .data_valid_i(dv8), .data_i(d8),
    .packet_type_i(pt8), .output_valid_o(ov8), .output_o(o8),
    .line_done_o(ld8), .line_pixel_count_o(cnt8), .residual_error_o(re8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] byte_mem [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int need_of(input int lanes, input int typ);
    case (typ)
      2: return lanes;
      3: return 5 * lanes / 4;
      4: return 3 * lanes / 2;
      5: return 7 * lanes / 4;
      default: return 0;
    endcase
  endfunction

  // Pixel k of the beat whose first byte is byte_mem[base], MSB-aligned in 16 bits.
  function automatic logic [127:0] exp_beat(input int lanes, input int typ, input int base);
    logic [127:0] r;
    int px, w, gb, i, lsb;
    r = '0;
    for (int k = 0; k < lanes; k++) begin
      case (typ)
        3: begin
          gb = base + 5 * (k / 4); i = k % 4; w = 10;
          px = (int'(byte_mem[gb+i]) << 2) | ((int'(byte_mem[gb+4]) >> (2 * i)) & 3);
        end
        4: begin
          gb = base + 3 * (k / 2); i = k % 2; w = 12;
          px = (int'(byte_mem[gb+i]) << 4) | ((int'(byte_mem[gb+2]) >> (4 * i)) & 15);
        end
        5: begin
          gb = base + 7 * (k / 4); i = k % 4; w = 14;
          lsb = int'(byte_mem[gb+4]) | (int'(byte_mem[gb+5]) << 8) | (int'(byte_mem[gb+6]) << 16);
          px = (int'(byte_mem[gb+i]) << 6) | ((lsb >> (6 * i)) & 63);
        end
        default: begin
          w = 8;
          px = int'(byte_mem[base+k]);
        end
      endcase
      r = r | (128'(px << (16 - w)) << ((lanes - 1 - k) * 16));
    end
    return r;
  endfunction

  function automatic logic obs_valid(input int lanes);
    return (lanes == 8) ? ov8 : ov4;
  endfunction
  function automatic logic [127:0] obs_out(input int lanes);
    return (lanes == 8) ? o8 : {64'h0, o4};
  endfunction
  function automatic logic obs_done(input int lanes);
    return (lanes == 8) ? ld8 : ld4;
  endfunction
  function automatic logic [15:0] obs_cnt(input int lanes);
    return (lanes == 8) ? cnt8 : cnt4;
  endfunction
  function automatic logic obs_res(input int lanes);
    return (lanes == 8) ? re8 : re4;
  endfunction

  task automatic drive(input int lanes, input logic v, input logic [63:0] d, input logic [2:0] t);
    if (lanes == 8) begin
      dv8 = v; d8 = d; pt8 = t;
    end else begin
      dv4 = v; d4 = d[31:0]; pt4 = t;
    end
  endtask

  task automatic check_beat(input int lanes, input bit has, input logic [127:0] exp, input string tag);
    chk({tag, "_valid"}, 128'(obs_valid(lanes)), 128'(has));
    chk({tag, "_data"}, obs_out(lanes), has ? exp : 128'h0);
    chk({tag, "_nodone"}, 128'(obs_done(lanes)), 128'h0);
  endtask

  // One line: nwords words, type typ latched on word 0; toggle scrambles the type afterwards.
  task automatic run_line(input int lanes, input int typ, input int nwords,
                          input bit toggle, input bit rnd, input string tag);
    int need, beats, idx, left;
    bit sup, pend;
    logic [127:0] pend_exp;
    logic [63:0] word;
    logic [2:0] t;
    need = need_of(lanes, typ);
    sup = (need != 0);
    beats = 0;
    pend = 1'b0;
    pend_exp = '0;
    for (int b = 0; b < nwords * lanes; b++)
      byte_mem[b] = rnd ? 8'($urandom_range(0, 255)) : 8'(b);
    for (int w = 0; w < nwords; w++) begin
      @(negedge clk);
      if (w > 0) check_beat(lanes, pend, pend_exp, $sformatf("%s_w%0d", tag, w - 1));
      word = '0;
      for (int b = 0; b < lanes; b++) word[8*b +: 8] = byte_mem[w*lanes + b];
      t = (w == 0 || !toggle) ? 3'(typ) : 3'($urandom_range(0, 7));
      drive(lanes, 1'b1, word, t);
      pend = 1'b0;
      pend_exp = '0;
      if (sup && (((w + 1) * lanes) / need > (w * lanes) / need)) begin
        idx = ((w + 1) * lanes) / need - 1;
        pend = 1'b1;
        pend_exp = exp_beat(lanes, typ, idx * need);
        beats++;
      end
    end
    @(negedge clk);
    check_beat(lanes, pend, pend_exp, $sformatf("%s_w%0d", tag, nwords - 1));
    drive(lanes, 1'b0, 64'h0, 3'(typ));
    @(negedge clk);
    left = nwords * lanes - beats * need;
    chk({tag, "_done"}, 128'(obs_done(lanes)), 128'h1);
    chk({tag, "_count"}, 128'(obs_cnt(lanes)), 128'(sup ? beats * lanes : 0));
    chk({tag, "_residual"}, 128'(obs_res(lanes)), 128'(sup && left != 0));
    chk({tag, "_idle_valid"}, 128'(obs_valid(lanes)), 128'h0);
    $display("line %s: lanes=%0d type=%0d words=%0d beats=%0d", tag, lanes, typ, nwords, beats);
  endtask

  initial begin
    logic [63:0] rw;
    rst = 1'b1;
    drive(4, 1'b0, 64'h0, 3'd0);
    drive(8, 1'b0, 64'h0, 3'd0);
    repeat (3) @(negedge clk);
    chk("reset_valid4", 128'(ov4), 128'h0);
    chk("reset_out4", {64'h0, o4}, 128'h0);
    chk("reset_done4", 128'(ld4), 128'h0);
    chk("reset_cnt4", 128'(cnt4), 128'h0);
    chk("reset_res4", 128'(re4), 128'h0);
    chk("reset_valid8", 128'(ov8), 128'h0);
    chk("reset_out8", o8, 128'h0);
    rst = 1'b0;

    run_line(4, 3, 5, 1'b0, 1'b0, "raw10_inc");
    run_line(8, 4, 3, 1'b0, 1'b1, "raw12_l8");
    run_line(4, 5, 7, 1'b0, 1'b1, "raw14_l4");
    run_line(4, 2, 1, 1'b0, 1'b1, "raw8_1w");
    run_line(4, 3, 2, 1'b0, 1'b1, "raw10_2w");
    run_line(4, 3, 10, 1'b1, 1'b1, "raw10_toggle");
    run_line(4, 0, 3, 1'b0, 1'b1, "unsup0");
    run_line(8, 5, 14, 1'b0, 1'b1, "raw14_l8");
    run_line(8, 3, 7, 1'b1, 1'b1, "raw10_l8_toggle");
    run_line(8, 2, 5, 1'b0, 1'b1, "raw8_l8");

    for (int i = 0; i < 8; i++)
      run_line(($urandom_range(0, 1) == 1) ? 8 : 4, int'($urandom_range(0, 7)),
               int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)), 1'b1,
               $sformatf("rand%0d", i));

    // Reset in the middle of a RAW14 line.
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      rw = {32'h0, $urandom()};
      drive(4, 1'b1, rw, 3'd5);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_valid", 128'(ov4), 128'h0);
    chk("midreset_out", {64'h0, o4}, 128'h0);
    chk("midreset_done", 128'(ld4), 128'h0);
    rst = 1'b0;
    drive(4, 1'b0, 64'h0, 3'd5);
    @(negedge clk);
    chk("midreset_nodone", 128'(ld4), 128'h0);
    @(negedge clk);
    chk("midreset_nodone2", 128'(ld4), 128'h0);
    $display("reset mid-line applied");
    run_line(4, 5, 7, 1'b0, 1'b1, "raw14_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mipi_rx_raw_depacker_gen.md
# mipi_rx_raw_depacker_gen

Parametrised successor to the 4-lane RAW10/12/14 depacker. It sits between the CSI-2 packet decoder and the pixel pipeline, and converts a lane-parallel byte stream into LANES pixels per output beat. A byte gearbox is used, so packing groups may straddle input words. The block supports RAW8/10/12/14 and reports per-line pixel count and residual-byte errors.

## Interface
Parameters:
- LANES, 4: input bytes per cycle and pixels per output beat; legal values are 4 and 8.
- PIXEL_WIDTH, 16: width of each output pixel slot; legal range 14..16.

Ports:
- clk_i  in  1  single clock for all logic.
- reset_i  in  1  synchronous, active-high reset.
- data_valid_i  in  1  high for the whole payload of one line packet; low between lines.
- data_i  in  8*LANES  payload bytes; data_i[7:0] is the earliest byte.
- packet_type_i  in  3  CSI data type & 3'h7: 2=RAW8, 3=RAW10, 4=RAW12, 5=RAW14; all other codes are unsupported.
- output_valid_o  out  1  output_o holds LANES valid pixels this cycle.
- output_o  out  PIXEL_WIDTH*LANES  pixels, MSB-aligned and zero-padded; the earliest pixel is in the most significant slot.
- line_done_o  out  1  one-cycle pulse after each line ends.
- line_pixel_count_o  out  16  pixels emitted in the line just ended; valid while line_done_o is high.
- residual_error_o  out  1  valid with line_done_o; high when leftover bytes at line end were nonzero.

## Operation
Type latching:
- packet_type_i is latched on the first valid cycle of a line.
- Changes to packet_type_i mid-line are ignored.

Beat size NEED (bytes per LANES-pixel beat) for the latched type:
- RAW8: LANES.
- RAW10: 5*LANES/4.
- RAW12: 3*LANES/2.
- RAW14: 7*LANES/4.

Byte buffer:
- Capacity is 3*LANES bytes, held with a fill count.
- On each valid cycle, LANES bytes are appended behind the existing content.
- If fill+LANES ≥ NEED, the oldest NEED bytes are consumed that cycle and one beat is emitted.
- At most one beat is emitted per cycle. This rate is sufficient because NEED ≥ LANES, so the buffer never overflows.

Unpacking, per group with bytes b0.. in arrival order:
- RAW8: p = b0.
- RAW10 (5 bytes, 4 pixels): pk = {bk, b4[2k+1:2k]}.
- RAW12 (3 bytes, 2 pixels): p0 = {b0, b2[3:0]}, p1 = {b1, b2[7:4]}.
- RAW14 (7 bytes, 4 pixels): MSBs are b0..b3. The LSBs come from L = {b6,b5,b4}, with pk = {bk, L[6k+5:6k]}.
- Each pixel is left-shifted so its MSB lands at bit PIXEL_WIDTH-1.

Unsupported type:
- Bytes are discarded and no beats are emitted.
- line_done_o still pulses at line end, with count 0 and residual_error_o = 0.

Line end (first cycle with data_valid_i low after a valid run):
- The fill count is cleared.
- residual_error_o = (fill ≠ 0).
- The pixel counter is captured into line_pixel_count_o, then cleared.
- The counter saturates at 16'hFFFF.

Lines are separated by at least one idle cycle. There is no backpressure.

## Timing
Reset:
- Reset takes effect on the next edge.
- All outputs go to 0; fill, counter and latched type are cleared.
- Reset mid-line discards the line and produces no line_done_o.

Output beats:
- Latency is 1 cycle: a beat completed by the data_i word at edge n is presented on output_o / output_valid_o during cycle n+1.
- When no beat is emitted in a cycle, output_valid_o = 0 and output_o = 0.

Line-end timing:
- Last valid word at cycle n, with data_valid_i low at cycle n+1.
- The final beat, if any, is visible in cycle n+1.
- line_done_o, line_pixel_count_o and residual_error_o are visible in cycle n+2, for one cycle only.

Steady state:
- RAW8: one beat every cycle.
- RAW10: 4 beats per 5 cycles.
- RAW12: 2 beats per 3 cycles.
- RAW14: 4 beats per 7 cycles.

## Test plan
- RAW10, LANES=4, 5 valid words of incrementing bytes 0x00.. -> exactly 4 beats, starting one cycle after word 2; first beat pixels {0x00,0x01,0x02,0x03} MSB-aligned with LSBs from byte 0x04; line_done_o with count 16, residual 0.
- RAW12, LANES=8, 3 words -> 2 beats straddling words; pixel 0 = {b0,b2[3:0]}<<4; count 16, residual 0.
- RAW14, LANES=4, 7 words of random data -> 4 beats matching the golden model; 14-bit pixels <<2; count 16.
- RAW8, 1 word then data_valid_i low, then RAW10 with 2 words -> first line count 4; second line gives 1 beat, count 4, residual_error_o = 1 (3 bytes left).
- packet_type_i toggled mid-line on a RAW10 line -> output is unaffected; unsupported type 0 -> no beats and count 0.
- reset_i asserted mid-RAW14 line -> outputs 0 next cycle, no line_done_o; the next clean line decodes correctly from fill 0.
